// File: rtl/snoop_responder.sv
// Snoop responder for a 4-line MSI cache.
// Watches the common data bus for misses and invalidates from other cores.
// It downgrades or invalidates local lines as needed. When a foreign miss
// hits a Modified line, it suppresses the memory reply and writes the dirty
// data back.
module snoop_responder (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [1:0]  MyId,
    input  logic        BusValid,
    input  logic [21:0] CDBIn,
    input  logic        LocalWe,
    input  logic [1:0]  LocalAddr,
    input  logic [1:0]  LocalState,
    input  logic [15:0] LocalData,
    input  logic [1:0]  QueryAddr,
    output logic [1:0]  QueryState,
    output logic [15:0] QueryData,
    output logic [15:0] WbData,
    output logic        dataWB,
    output logic        abortMem,
    output logic        Busy,
    output logic        Overrun
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ABORT  = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RM   = 2'b01;
    localparam logic [1:0] OP_WM   = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        addr_q, addr_d;
    logic [3:0][1:0]   line_state_q, line_state_d;
    logic [3:0][15:0]  line_data_q, line_data_d;
    logic [15:0]       wb_data_q, wb_data_d;
    logic              data_wb_q, data_wb_d;
    logic              abort_mem_q, abort_mem_d;
    logic              overrun_q, overrun_d;

    logic [1:0]        bus_op;
    logic [1:0]        bus_src;
    logic [1:0]        bus_addr;
    logic              foreign_tx;
    logic              busy;
    logic [1:0]        lookup_state;
    logic              unused_bus_data;

    // Bus word field decode; the snooper never consumes the bus data field
    assign bus_op          = CDBIn[21:20];
    assign bus_src         = CDBIn[19:18];
    assign bus_addr        = CDBIn[17:16];
    assign unused_bus_data = ^CDBIn[15:0];

    assign foreign_tx   = BusValid && (bus_op != OP_NONE) && (bus_src != MyId);
    assign busy         = (state_q != ST_IDLE);
    assign lookup_state = line_state_q[addr_q];

    // Next-state logic: local writes, capture, lookup decisions and write-back sequencing
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        line_state_d = line_state_q;
        line_data_d  = line_data_q;
        wb_data_d    = wb_data_q;
        data_wb_d    = 1'b0;
        abort_mem_d  = 1'b0;
        overrun_d    = overrun_q;

        // Local updates land at the same edge as a capture, so LOOKUP sees them
        if (LocalWe && !busy) begin
            line_state_d[LocalAddr] = (LocalState == 2'b11) ? MSI_I : LocalState;
            line_data_d[LocalAddr]  = LocalData;
        end

        if (foreign_tx && busy) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (foreign_tx) begin
                    op_d    = bus_op;
                    addr_d  = bus_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_IDLE;
                if (lookup_state == MSI_M) begin
                    if (op_q == OP_INV) begin
                        line_state_d[addr_q] = MSI_I;
                    end else begin
                        state_d     = ST_ABORT;
                        abort_mem_d = 1'b1;
                    end
                end else if (lookup_state == MSI_S && op_q != OP_RM) begin
                    line_state_d[addr_q] = MSI_I;
                end
            end
            ST_ABORT: begin
                state_d   = ST_WB;
                data_wb_d = 1'b1;
                wb_data_d = line_data_q[addr_q];
            end
            ST_WB: begin
                line_state_d[addr_q] = (op_q == OP_RM) ? MSI_S : MSI_I;
                state_d              = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, line storage and registered outputs; reset wipes any pending write-back
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NONE;
            addr_q       <= 2'd0;
            line_state_q <= '0;
            line_data_q  <= '0;
            wb_data_q    <= 16'h0000;
            data_wb_q    <= 1'b0;
            abort_mem_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            line_state_q <= line_state_d;
            line_data_q  <= line_data_d;
            wb_data_q    <= wb_data_d;
            data_wb_q    <= data_wb_d;
            abort_mem_q  <= abort_mem_d;
            overrun_q    <= overrun_d;
        end
    end

    assign QueryState = line_state_q[QueryAddr];
    assign QueryData  = line_data_q[QueryAddr];
    assign WbData     = wb_data_q;
    assign dataWB     = data_wb_q;
    assign abortMem   = abort_mem_q;
    assign Busy       = busy;
    assign Overrun    = overrun_q;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed testbench for snoop_responder with hand-computed expectations.
module tb_snoop_responder;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [1:0]  MyId;
    logic        BusValid;
    logic [21:0] CDBIn;
    logic        LocalWe;
    logic [1:0]  LocalAddr;
    logic [1:0]  LocalState;
    logic [15:0] LocalData;
    logic [1:0]  QueryAddr;
    logic [1:0]  QueryState;
    logic [15:0] QueryData;
    logic [15:0] WbData;
    logic        dataWB;
    logic        abortMem;
    logic        Busy;
    logic        Overrun;

    int errorCount = 0;
    int checkCount = 0;

    snoop_responder dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .MyId       (MyId),
        .BusValid   (BusValid),
        .CDBIn      (CDBIn),
        .LocalWe    (LocalWe),
        .LocalAddr  (LocalAddr),
        .LocalState (LocalState),
        .LocalData  (LocalData),
        .QueryAddr  (QueryAddr),
        .QueryState (QueryState),
        .QueryData  (QueryData),
        .WbData     (WbData),
        .dataWB     (dataWB),
        .abortMem   (abortMem),
        .Busy       (Busy),
        .Overrun    (Overrun)
    );

    // Free-running 10-unit clock
    always #5 Clock = ~Clock;

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input logic busValid, input logic [1:0] op, input logic [1:0] src,
                                 input logic [1:0] addr, input logic localWe, input logic [1:0] lAddr,
                                 input logic [1:0] lState, input logic [15:0] lData);
        BusValid   = busValid;
        CDBIn      = {op, src, addr, 16'h0000};
        LocalWe    = localWe;
        LocalAddr  = lAddr;
        LocalState = lState;
        LocalData  = lData;
    endtask

    task automatic idleInputs;
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
    endtask

    task automatic localWrite(input logic [1:0] addr, input logic [1:0] st, input logic [15:0] data);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, addr, st, data);
        tick;
        idleInputs;
    endtask

    task automatic checkLine(input string tag, input logic [1:0] addr, input logic [1:0] expState,
                             input logic [15:0] expData);
        QueryAddr = addr;
        #1;
        checkOutput({tag, ".state"}, {30'd0, QueryState}, {30'd0, expState});
        checkOutput({tag, ".data"}, {16'd0, QueryData}, {16'd0, expData});
    endtask

    task automatic checkPorts(input string tag, input logic expBusy, input logic expAbort, input logic expWb);
        checkOutput({tag, ".Busy"}, {31'd0, Busy}, {31'd0, expBusy});
        checkOutput({tag, ".abortMem"}, {31'd0, abortMem}, {31'd0, expAbort});
        checkOutput({tag, ".dataWB"}, {31'd0, dataWB}, {31'd0, expWb});
    endtask

    initial begin
        Resetn    = 1'b0;
        MyId      = 2'd0;
        QueryAddr = 2'd0;
        idleInputs;
        #1;

        // Reset state
        checkPorts("rst", 1'b0, 1'b0, 1'b0);
        checkOutput("rst.Overrun", {31'd0, Overrun}, 32'd0);
        checkOutput("rst.WbData", {16'd0, WbData}, 32'd0);
        repeat (2) tick;
        Resetn = 1'b1;
        checkLine("rst.line0", 2'd0, 2'b00, 16'h0000);
        checkLine("rst.line3", 2'd3, 2'b00, 16'h0000);

        // Read miss on a Modified line: abort, write back, downgrade to S
        localWrite(2'd2, 2'b10, 16'hBEEF);
        checkLine("s1.install", 2'd2, 2'b10, 16'hBEEF);
        applyStimulus(1'b1, 2'b01, 2'd1, 2'd2, 1'b0, 2'd0, 2'b00, 16'h0000);
        tick;
        idleInputs;
        checkPorts("s1.lookup", 1'b1, 1'b0, 1'b0);
        tick;
        checkPorts("s1.abort", 1'b1, 1'b1, 1'b0);
        tick;
        checkPorts("s1.wb", 1'b1, 1'b0, 1'b1);
        checkOutput("s1.WbData", {16'd0, WbData}, 32'h0000BEEF);
        tick;
        checkPorts("s1.idle", 1'b0, 1'b0, 1'b0);
        checkOutput("s1.WbDataHold", {16'd0, WbData}, 32'h0000BEEF);
        checkLine("s1.line2", 2'd2, 2'b01, 16'hBEEF);

        // Write miss on a Shared line: invalidate with no bus action
        localWrite(2'd1, 2'b01, 16'h1234);
        applyStimulus(1'b1, 2'b10, 2'd3, 2'd1, 1'b0, 2'd0, 2'b00, 16'h0000);
        tick;
        idleInputs;
        checkPorts("s2.lookup", 1'b1, 1'b0, 1'b0);
        checkLine("s2.before", 2'd1, 2'b01, 16'h1234);
        tick;
        checkPorts("s2.idle", 1'b0, 1'b0, 1'b0);
        checkLine("s2.after", 2'd1, 2'b00, 16'h1234);

        // Own-ID transaction is ignored
        localWrite(2'd0, 2'b10, 16'h5A5A);
        applyStimulus(1'b1, 2'b10, 2'd0, 2'd0, 1'b0, 2'd0, 2'b00, 16'h0000);
        tick;
        idleInputs;
        checkPorts("s3.own", 1'b0, 1'b0, 1'b0);
        checkLine("s3.line0", 2'd0, 2'b10, 16'h5A5A);
        tick;
        checkPorts("s3.later", 1'b0, 1'b0, 1'b0);

        // Second foreign miss while busy is dropped; local write while busy ignored
        localWrite(2'd3, 2'b10, 16'hCAFE);
        checkOutput("s4.OverrunPre", {31'd0, Overrun}, 32'd0);
        applyStimulus(1'b1, 2'b01, 2'd2, 2'd3, 1'b0, 2'd0, 2'b00, 16'h0000);
        tick;
        applyStimulus(1'b1, 2'b10, 2'd1, 2'd0, 1'b0, 2'd0, 2'b00, 16'h0000);
        tick;
        idleInputs;
        checkOutput("s4.Overrun", {31'd0, Overrun}, 32'd1);
        checkPorts("s4.abort", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 2'd0, 2'd0, 1'b1, 2'd1, 2'b10, 16'hFFFF);
        tick;
        idleInputs;
        checkPorts("s4.wb", 1'b1, 1'b0, 1'b1);
        checkOutput("s4.WbData", {16'd0, WbData}, 32'h0000CAFE);
        tick;
        checkPorts("s4.idle", 1'b0, 1'b0, 1'b0);
        checkLine("s4.line3", 2'd3, 2'b01, 16'hCAFE);
        checkLine("s4.line0", 2'd0, 2'b10, 16'h5A5A);
        checkLine("s4.line1", 2'd1, 2'b00, 16'h1234);
        checkOutput("s4.OverrunSticky", {31'd0, Overrun}, 32'd1);

        // Reserved local state writes I
        localWrite(2'd1, 2'b11, 16'hABCD);
        checkLine("s4.reserved", 2'd1, 2'b00, 16'hABCD);

        // Reset during ABORT cancels the write-back
        localWrite(2'd2, 2'b10, 16'h7777);
        applyStimulus(1'b1, 2'b01, 2'd1, 2'd2, 1'b0, 2'd0, 2'b00, 16'h0000);
        tick;
        idleInputs;
        tick;
        checkPorts("s5.abort", 1'b1, 1'b1, 1'b0);
        Resetn = 1'b0;
        #1;
        checkPorts("s5.rst", 1'b0, 1'b0, 1'b0);
        checkOutput("s5.Overrun", {31'd0, Overrun}, 32'd0);
        checkOutput("s5.WbData", {16'd0, WbData}, 32'd0);
        checkLine("s5.line2", 2'd2, 2'b00, 16'h0000);
        checkLine("s5.line0", 2'd0, 2'b00, 16'h0000);
        tick;
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checkPorts("s5.post", 1'b0, 1'b0, 1'b0);
        end
        checkLine("s5.line3", 2'd3, 2'b00, 16'h0000);

        // Local install and invalidate in the same cycle: lookup sees S, ends I
        applyStimulus(1'b1, 2'b11, 2'd2, 2'd0, 1'b1, 2'd0, 2'b01, 16'h1111);
        tick;
        idleInputs;
        checkPorts("s6.lookup", 1'b1, 1'b0, 1'b0);
        checkLine("s6.mid", 2'd0, 2'b01, 16'h1111);
        tick;
        checkPorts("s6.idle", 1'b0, 1'b0, 1'b0);
        checkLine("s6.end", 2'd0, 2'b00, 16'h1111);
        tick;
        checkPorts("s6.nowb", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
